// File: rtl/fb_port_arbiter_if.sv
// Bundle of display-read, camera-write, status and frame-buffer RAM signals around fb_port_arbiter.
// The slave modport is the arbiter's view. The master modport is the view of the clients and RAM around it.
interface fb_port_arbiter_if #(
  parameter int C_NB_ADDR   = 13,
  parameter int C_NB_DATA   = 12,
  parameter int C_FIFO_LOG2 = 2
);
  logic                   disp_rd_req;
  logic [C_NB_ADDR-1:0]   disp_rd_addr;
  logic [C_NB_DATA-1:0]   disp_rd_data;
  logic                   disp_rd_valid;
  logic                   cam_wr_req;
  logic [C_NB_ADDR-1:0]   cam_wr_addr;
  logic [C_NB_DATA-1:0]   cam_wr_data;
  logic                   ovf_clr;
  logic                   ovf;
  logic [C_FIFO_LOG2:0]   fifo_level;
  logic                   mem_en;
  logic                   mem_we;
  logic [C_NB_ADDR-1:0]   mem_addr;
  logic [C_NB_DATA-1:0]   mem_wdata;
  logic [C_NB_DATA-1:0]   mem_rdata;

  modport master (
    output disp_rd_req, disp_rd_addr, cam_wr_req, cam_wr_addr, cam_wr_data,
           ovf_clr, mem_rdata,
    input  disp_rd_data, disp_rd_valid, ovf, fifo_level,
           mem_en, mem_we, mem_addr, mem_wdata
  );

  modport slave (
    input  disp_rd_req, disp_rd_addr, cam_wr_req, cam_wr_addr, cam_wr_data,
           ovf_clr, mem_rdata,
    output disp_rd_data, disp_rd_valid, ovf, fifo_level,
           mem_en, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/fb_port_arbiter.sv
// Single-port frame-buffer arbiter: display reads win every cycle, camera writes queue in a FIFO and drain into idle cycles.
// Optional macro FB_ARB_DROP_CNT_EN adds a saturating 16-bit drop_cnt output.
module fb_port_arbiter #(
  parameter int C_NB_ADDR   = 13,
  parameter int C_NB_DATA   = 12,
  parameter int C_FIFO_LOG2 = 2
) (
  input  logic                clk,
  input  logic                rst,
  fb_port_arbiter_if.slave    bus
`ifdef FB_ARB_DROP_CNT_EN
  ,
  output logic [15:0]         drop_cnt
`endif
);

  localparam int C_DEPTH = 1 << C_FIFO_LOG2;
  localparam logic [C_FIFO_LOG2:0]   C_FULL    = {1'b1, {C_FIFO_LOG2{1'b0}}};
  localparam logic [C_FIFO_LOG2:0]   C_LVL_ONE = {{C_FIFO_LOG2{1'b0}}, 1'b1};
  localparam logic [C_FIFO_LOG2-1:0] C_PTR_ONE = {{(C_FIFO_LOG2-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    GRANT_IDLE,
    GRANT_READ,
    GRANT_WRITE
  } grant_t;

  grant_t                  grant;
  logic [C_NB_ADDR-1:0]    fifo_addr [C_DEPTH];
  logic [C_NB_DATA-1:0]    fifo_data [C_DEPTH];
  logic [C_FIFO_LOG2-1:0]  wr_ptr;
  logic [C_FIFO_LOG2-1:0]  rd_ptr;
  logic [C_FIFO_LOG2:0]    level;
  logic                    rd_valid;
  logic                    ovf_flag;
  logic                    empty;
  logic                    full;
  logic                    pop;
  logic                    push;
  logic                    drop;

  // A full FIFO can still accept a write when its head drains in the same cycle.
  always_comb begin
    empty = (level == '0);
    full  = (level == C_FULL);
    pop   = !bus.disp_rd_req && !empty;
    push  = bus.cam_wr_req && (!full || pop);
    drop  = bus.cam_wr_req && full && !pop;
  end

  always_comb begin
    grant = GRANT_IDLE;
    if (bus.disp_rd_req) begin
      grant = GRANT_READ;
    end else if (!empty) begin
      grant = GRANT_WRITE;
    end
  end

  always_comb begin
    bus.mem_en    = 1'b0;
    bus.mem_we    = 1'b0;
    bus.mem_addr  = '0;
    bus.mem_wdata = '0;
    unique case (grant)
      GRANT_READ: begin
        bus.mem_en   = 1'b1;
        bus.mem_addr = bus.disp_rd_addr;
      end
      GRANT_WRITE: begin
        bus.mem_en    = 1'b1;
        bus.mem_we    = 1'b1;
        bus.mem_addr  = fifo_addr[rd_ptr];
        bus.mem_wdata = fifo_data[rd_ptr];
      end
      default: begin
        bus.mem_en = 1'b0;
      end
    endcase
  end

  // Storage needs no reset; only the pointers and level define validity.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_addr[wr_ptr] <= bus.cam_wr_addr;
      fifo_data[wr_ptr] <= bus.cam_wr_data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + C_PTR_ONE;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + C_PTR_ONE;
      end
      if (push && !pop) begin
        level <= level + C_LVL_ONE;
      end else if (pop && !push) begin
        level <= level - C_LVL_ONE;
      end
    end
  end

  // A drop in the same cycle as ovf_clr keeps the flag set.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ovf_flag <= 1'b0;
      rd_valid <= 1'b0;
    end else begin
      rd_valid <= bus.disp_rd_req;
      if (drop) begin
        ovf_flag <= 1'b1;
      end else if (bus.ovf_clr) begin
        ovf_flag <= 1'b0;
      end
    end
  end

`ifdef FB_ARB_DROP_CNT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      drop_cnt <= 16'd0;
    end else if (drop) begin
      if (bus.ovf_clr) begin
        drop_cnt <= 16'd1;
      end else if (drop_cnt != 16'hFFFF) begin
        drop_cnt <= drop_cnt + 16'd1;
      end
    end else if (bus.ovf_clr) begin
      drop_cnt <= 16'd0;
    end
  end
`endif

  always_comb begin
    bus.disp_rd_valid = rd_valid;
    bus.disp_rd_data  = bus.mem_rdata;
    bus.ovf           = ovf_flag;
    bus.fifo_level    = level;
  end

endmodule

// File: tb/tb_fb_port_arbiter.sv
// Scoreboard bench for fb_port_arbiter with a behavioural 1-cycle-latency RAM.
// Defining FB_ARB_DROP_CNT_EN adds the drop counter checks.
module tb_fb_port_arbiter;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_fail;

  fb_port_arbiter_if #(.C_NB_ADDR(13), .C_NB_DATA(12), .C_FIFO_LOG2(2)) bus ();

`ifdef FB_ARB_DROP_CNT_EN
  logic [15:0] drop_cnt;
`endif

  fb_port_arbiter #(.C_NB_ADDR(13), .C_NB_DATA(12), .C_FIFO_LOG2(2)) dut (
    .clk      (clk),
    .rst      (rst),
    .bus      (bus.slave)
`ifdef FB_ARB_DROP_CNT_EN
    ,
    .drop_cnt (drop_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Untouched RAM words hold a fixed pattern, so read data is predictable without a preload.
  function automatic logic [11:0] exp_pix(input logic [12:0] a);
    if (a == 13'h010) return 12'hABC;
    return a[11:0] ^ 12'h5A5;
  endfunction

  logic [11:0] ram_val [8192];
  bit          ram_written [8192];

  always @(posedge clk) begin
    if (bus.mem_en) begin
      if (bus.mem_we) begin
        ram_val[bus.mem_addr]     <= bus.mem_wdata;
        ram_written[bus.mem_addr] <= 1'b1;
      end else begin
        bus.mem_rdata <= ram_written[bus.mem_addr] ? ram_val[bus.mem_addr]
                                                   : exp_pix(bus.mem_addr);
      end
    end
  end

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic applyStimulus(input logic req, input logic [12:0] raddr,
                               input logic cam, input logic [12:0] waddr,
                               input logic [11:0] wdata, input logic clr);
    bus.disp_rd_req  = req;
    bus.disp_rd_addr = raddr;
    bus.cam_wr_req   = cam;
    bus.cam_wr_addr  = waddr;
    bus.cam_wr_data  = wdata;
    bus.ovf_clr      = clr;
    @(posedge clk);
    #1;
  endtask

  logic [24:0] wq[$];
  logic [11:0] rq[$];
  logic [2:0]  m_level;
  logic        m_ovf;
  logic        m_valid;
  logic [15:0] m_cnt;
  logic        m_pop;
  logic        m_drop;
  logic [24:0] m_head;
  logic [11:0] m_rd;

  initial begin
    m_level = '0;
    m_ovf   = 1'b0;
    m_valid = 1'b0;
    m_cnt   = '0;
  end

  // Reference model of the arbiter, stepped once per cycle at the falling edge.
  always @(negedge clk) begin
    if (rst) begin
      checkOutput("rst_fifo_level", 32'(bus.fifo_level), 32'd0);
      checkOutput("rst_ovf", 32'(bus.ovf), 32'd0);
      checkOutput("rst_rd_valid", 32'(bus.disp_rd_valid), 32'd0);
      checkOutput("rst_mem_we", 32'(bus.mem_we), 32'd0);
      wq.delete();
      rq.delete();
      m_level = '0;
      m_ovf   = 1'b0;
      m_valid = 1'b0;
      m_cnt   = '0;
    end else begin
      checkOutput("fifo_level", 32'(bus.fifo_level), 32'(m_level));
      checkOutput("ovf", 32'(bus.ovf), 32'(m_ovf));
      checkOutput("rd_valid", 32'(bus.disp_rd_valid), 32'(m_valid));
`ifdef FB_ARB_DROP_CNT_EN
      checkOutput("drop_cnt", 32'(drop_cnt), 32'(m_cnt));
`endif
      if (m_valid && rq.size() > 0) begin
        m_rd = rq.pop_front();
        checkOutput("rd_data", 32'(bus.disp_rd_data), 32'(m_rd));
      end
      m_pop = !bus.disp_rd_req && (m_level != 3'd0);
      if (bus.disp_rd_req) begin
        checkOutput("rd_mem_en", 32'(bus.mem_en), 32'd1);
        checkOutput("rd_mem_we", 32'(bus.mem_we), 32'd0);
        checkOutput("rd_mem_addr", 32'(bus.mem_addr), 32'(bus.disp_rd_addr));
        rq.push_back(exp_pix(bus.disp_rd_addr));
      end else if (m_pop && wq.size() > 0) begin
        m_head = wq.pop_front();
        checkOutput("wr_mem_en", 32'(bus.mem_en), 32'd1);
        checkOutput("wr_mem_we", 32'(bus.mem_we), 32'd1);
        checkOutput("wr_mem_addr", 32'(bus.mem_addr), 32'(m_head[24:12]));
        checkOutput("wr_mem_wdata", 32'(bus.mem_wdata), 32'(m_head[11:0]));
      end else begin
        checkOutput("idle_mem_en", 32'(bus.mem_en), 32'd0);
        checkOutput("idle_mem_we", 32'(bus.mem_we), 32'd0);
        checkOutput("idle_mem_addr", 32'(bus.mem_addr), 32'd0);
        checkOutput("idle_mem_wdata", 32'(bus.mem_wdata), 32'd0);
      end
      m_drop = 1'b0;
      if (bus.cam_wr_req) begin
        if (m_level < 3'd4 || m_pop) begin
          wq.push_back({bus.cam_wr_addr, bus.cam_wr_data});
          if (!m_pop) m_level = m_level + 3'd1;
        end else begin
          m_drop = 1'b1;
        end
      end else if (m_pop) begin
        m_level = m_level - 3'd1;
      end
      if (m_drop) m_ovf = 1'b1;
      else if (bus.ovf_clr) m_ovf = 1'b0;
      if (m_drop) m_cnt = bus.ovf_clr ? 16'd1 : ((m_cnt == 16'hFFFF) ? m_cnt : m_cnt + 16'd1);
      else if (bus.ovf_clr) m_cnt = 16'd0;
      m_valid = bus.disp_rd_req;
    end
  end

  initial begin
    n_checks = 0;
    n_fail   = 0;
    rst      = 1'b1;
    bus.disp_rd_req  = 1'b0;
    bus.disp_rd_addr = '0;
    bus.cam_wr_req   = 1'b0;
    bus.cam_wr_addr  = '0;
    bus.cam_wr_data  = '0;
    bus.ovf_clr      = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    applyStimulus(1'b1, 13'h010, 1'b0, 13'h0, 12'h0, 1'b0);
    repeat (2) applyStimulus(1'b0, 13'h0, 1'b0, 13'h0, 12'h0, 1'b0);

    applyStimulus(1'b0, 13'h0, 1'b1, 13'h005, 12'h111, 1'b0);
    applyStimulus(1'b0, 13'h0, 1'b1, 13'h006, 12'h222, 1'b0);
    applyStimulus(1'b0, 13'h0, 1'b1, 13'h007, 12'h333, 1'b0);
    repeat (4) applyStimulus(1'b0, 13'h0, 1'b0, 13'h0, 12'h0, 1'b0);

    for (int i = 0; i < 10; i++) begin
      applyStimulus(1'b1, 13'h100 + 13'(i), (i < 4), 13'h020 + 13'(i), 12'h400 + 12'(i), 1'b0);
    end
    checkOutput("burst_level", 32'(bus.fifo_level), 32'd4);
    repeat (6) applyStimulus(1'b0, 13'h0, 1'b0, 13'h0, 12'h0, 1'b0);

    for (int i = 0; i < 4; i++) begin
      applyStimulus(1'b1, 13'h180 + 13'(i), 1'b1, 13'h030 + 13'(i), 12'h530 + 12'(i), 1'b0);
    end
    applyStimulus(1'b1, 13'h184, 1'b1, 13'h034, 12'h534, 1'b0);
    checkOutput("ovf_set", 32'(bus.ovf), 32'd1);
    applyStimulus(1'b1, 13'h185, 1'b1, 13'h035, 12'h535, 1'b1);
    checkOutput("ovf_set_wins", 32'(bus.ovf), 32'd1);
    applyStimulus(1'b1, 13'h186, 1'b0, 13'h0, 12'h0, 1'b1);
    checkOutput("ovf_cleared", 32'(bus.ovf), 32'd0);
    applyStimulus(1'b0, 13'h0, 1'b1, 13'h036, 12'h536, 1'b0);
    checkOutput("full_pushpop_level", 32'(bus.fifo_level), 32'd4);
    checkOutput("full_pushpop_ovf", 32'(bus.ovf), 32'd0);
    repeat (6) applyStimulus(1'b0, 13'h0, 1'b0, 13'h0, 12'h0, 1'b0);

    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b1, 13'h1C0 + 13'(i), 1'b1, 13'h040 + 13'(i), 12'h640 + 12'(i), 1'b0);
    end
    bus.cam_wr_req = 1'b0;
    #3 rst = 1'b1;
    #1;
    checkOutput("midrst_level", 32'(bus.fifo_level), 32'd0);
    checkOutput("midrst_ovf", 32'(bus.ovf), 32'd0);
    checkOutput("midrst_rd_valid", 32'(bus.disp_rd_valid), 32'd0);
    bus.disp_rd_req = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    repeat (5) applyStimulus(1'b0, 13'h0, 1'b0, 13'h0, 12'h0, 1'b0);

`ifdef FB_ARB_DROP_CNT_EN
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1'b1, 13'h100, 1'b1, 13'h050 + 13'(i), 12'h750 + 12'(i), 1'b0);
    end
    for (int i = 0; i < 70000; i++) begin
      applyStimulus(1'b1, 13'h100, 1'b1, 13'h060, 12'h760, 1'b0);
    end
    checkOutput("drop_cnt_sat", 32'(drop_cnt), 32'h0000FFFF);
    applyStimulus(1'b0, 13'h0, 1'b0, 13'h0, 12'h0, 1'b1);
    checkOutput("drop_cnt_clr", 32'(drop_cnt), 32'd0);
    repeat (5) applyStimulus(1'b0, 13'h0, 1'b0, 13'h0, 12'h0, 1'b0);
`endif

    checkOutput("ram_5", 32'(ram_val[5]), 32'h111);
    checkOutput("ram_6", 32'(ram_val[6]), 32'h222);
    checkOutput("ram_7", 32'(ram_val[7]), 32'h333);
    checkOutput("ram_23", 32'(ram_val[13'h023]), 32'h403);
    checkOutput("ram_36", 32'(ram_val[13'h036]), 32'h536);
    checkOutput("ram_34_dropped", 32'(ram_written[13'h034]), 32'd0);
    checkOutput("ram_40_discarded", 32'(ram_written[13'h040]), 32'd0);
    checkOutput("wq_drained", 32'(wq.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/fb_port_arbiter.md
Name: fb_port_arbiter

Overview:
- Shares one single-port synchronous frame-buffer RAM (80x60 pixels, 12-bit RGB444) between two requesters: the camera capture writer and the VGA display reader.
- Display reads have hard real-time priority and a fixed 1-cycle read latency.
- Camera writes are absorbed by a small write FIFO and drained into free RAM cycles.
- Sits between the capture block, the display block and the frame-buffer RAM.

Parameters:
C_NB_ADDR, 13, frame-buffer address width (80*60=4800 fits in 2^13)
C_NB_DATA, 12, pixel word width (4+4+4)
C_FIFO_LOG2, 2, log2 of write-FIFO depth (default depth 4)

Ports:
clk  in  1  system clock
rst  in  1  reset, asynchronous, active-high
disp_rd_req  in  1  display read request, one pixel per asserted cycle
disp_rd_addr  in  C_NB_ADDR  display read address
disp_rd_data  out  C_NB_DATA  read data, equal to mem_rdata (passthrough)
disp_rd_valid  out  1  high 1 cycle after each granted read
cam_wr_req  in  1  camera write strobe (cannot be stalled)
cam_wr_addr  in  C_NB_ADDR  camera write address
cam_wr_data  in  C_NB_DATA  camera pixel
ovf_clr  in  1  clears sticky overflow flag
ovf  out  1  sticky: at least one camera write dropped
fifo_level  out  C_FIFO_LOG2+1  current FIFO occupancy
mem_en  out  1  RAM enable
mem_we  out  1  RAM write enable
mem_addr  out  C_NB_ADDR  RAM address
mem_wdata  out  C_NB_DATA  RAM write data
mem_rdata  in  C_NB_DATA  RAM read data (registered in RAM, 1-cycle latency)

Behaviour:
- Reset (async): FIFO empty, fifo_level=0, ovf=0, disp_rd_valid=0. mem_en, mem_we, mem_addr and mem_wdata are 0 while the FIFO is empty and there is no request.
- Grant per cycle (combinational from current inputs and FIFO head), in priority order:
  - If disp_rd_req=1, grant READ: mem_en=1, mem_we=0, mem_addr=disp_rd_addr.
  - Else if the FIFO is not empty, grant WRITE: mem_en=1, mem_we=1, mem_addr/mem_wdata = FIFO head, and pop the FIFO this cycle.
  - Else IDLE: mem_en=0, mem_we=0.
- Read latency: disp_rd_valid is registered to disp_rd_req of the previous cycle. disp_rd_data is valid whenever disp_rd_valid=1.
- Push:
  - cam_wr_req=1 pushes {addr,data} at the clock edge if the FIFO is not full, or if it is full and a pop occurs in the same cycle.
  - Push and pop in the same cycle leave fifo_level unchanged.
  - cam_wr_req=1 while full with no pop: the write is dropped, FIFO content is unchanged, and ovf<=1.
- A write to an empty FIFO is never written to RAM in the same cycle it is pushed. Minimum push-to-RAM latency is 1 cycle.
- Write order is strictly FIFO. Pointers wrap modulo 2^C_FIFO_LOG2. fifo_level ranges 0..2^C_FIFO_LOG2.
- ovf_clr and a new drop in the same cycle: set wins, so ovf stays 1.
- Reset mid-operation: pending FIFO writes are discarded. A read in flight produces no disp_rd_valid.
- No RAW forwarding: a read of an address still queued in the FIFO returns the old RAM content. This is acceptable for display.

Optional Feature:
- Macro: FB_ARB_DROP_CNT_EN.
- When defined, an extra output drop_cnt (16 bits) counts dropped camera writes.
  - Saturates at 16'hFFFF.
  - Cleared by ovf_clr unless a drop occurs in the same cycle, in which case it loads 1.
  - Reset value 0.
- When undefined, the port and counter do not exist. ovf behaviour is identical in both cases.

Test Plan:
- Single read: disp_rd_req=1, addr=0x010, RAM[0x010]=0xABC -> mem_we=0, mem_addr=0x010 in that cycle; next cycle disp_rd_valid=1 and disp_rd_data=0xABC.
- Idle drain: 3 camera writes (addr 5,6,7; data 0x111,0x222,0x333) with no reads -> RAM writes occur in order on the 3 following cycles. fifo_level reads 1 after the first push and 0 after the last pop.
- Read priority: disp_rd_req held high for 10 cycles while 4 writes are pushed -> no mem_we during the read burst and fifo_level=4. After the burst, 4 writes drain in 4 cycles with the original data.
- Overflow: FIFO full plus a 5th write with disp_rd_req=1 -> write dropped, ovf=1, FIFO content unchanged. ovf_clr together with a drop in the same cycle -> ovf stays 1. ovf_clr alone -> ovf=0.
- Full push+pop: FIFO full, disp_rd_req=0, cam_wr_req=1 -> push accepted, fifo_level stays 4, ovf stays 0.
- Reset mid-burst: assert rst with fifo_level=3 and a read pending -> fifo_level=0, ovf=0, disp_rd_valid=0 immediately, no RAM writes after release. With FB_ARB_DROP_CNT_EN, 70000 drops -> drop_cnt=16'hFFFF.
